// File: rtl/reg_hazard_pkg.sv
// Shared definitions for the ID-stage hazard unit: register numbers,
// forwarding-select encodings and the per-stage destination record.
package reg_hazard_pkg;

    localparam int CNT_W = 8;

    localparam logic [5:0] REG_ZERO = 6'd0;
    localparam logic [5:0] REG_V0   = 6'd2;
    localparam logic [5:0] REG_A0   = 6'd4;
    localparam logic [5:0] REG_RA   = 6'd31;
    localparam logic [5:0] REG_HILO = 6'd33;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic       valid;
        logic [5:0] dest;
        logic       is_load;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{valid: 1'b0, dest: 6'd0, is_load: 1'b0};

    // Register 0 is hardwired, so a stage writing it never supplies an operand.
    function automatic logic stage_match(input stage_t s, input logic [5:0] r);
        return s.valid && (r != REG_ZERO) && (s.dest == r);
    endfunction

endpackage

// File: rtl/reg_hazard_unit_hilo_busy_counter.sv
// Down-counter that holds HI/LO busy while a MULTU/DIVU is in flight.
module hilo_busy_counter
    import reg_hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_en,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_busy
);

    logic [CNT_W-1:0] r_count;

    // A new load overrides the decrement on the same edge; zero is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load_en) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_busy = (r_count != '0);

endmodule

// File: rtl/reg_hazard_unit.sv
// ID-stage hazard unit: tracks EX/MEM/WB destinations, selects operand
// forwarding sources and stalls on load-use and HI/LO-busy hazards.
module reg_hazard_unit
    import reg_hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [5:0] id_rr1,
    input  logic [5:0] id_rr2,
    input  logic [5:0] id_wr,
    input  logic       id_is_load,
    input  logic       id_is_mul,
    input  logic       id_is_div,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd1,
    output logic [1:0] fwd2,
    output logic       hilo_busy
);

    stage_t r_ex, r_mem, r_wb;

    logic             w_issue;
    logic             w_load_use;
    logic             w_hilo_haz;
    logic             w_hilo_busy;
    logic             w_hilo_load;
    logic [CNT_W-1:0] w_hilo_val;

    // An instruction leaves ID (id_valid, not stalled, not flushed) exactly
    // when it is written into EX; otherwise EX receives a bubble.
    assign w_issue = id_valid && !stall && !flush;

    assign w_load_use =
        (r_ex.is_load  && (stage_match(r_ex,  id_rr1) || stage_match(r_ex,  id_rr2))) ||
        (r_mem.is_load && (stage_match(r_mem, id_rr1) || stage_match(r_mem, id_rr2)));

    assign w_hilo_haz = w_hilo_busy &&
        ((id_rr1 == REG_HILO) || (id_rr2 == REG_HILO) || id_is_mul || id_is_div);

    assign stall = !flush && id_valid && (w_load_use || w_hilo_haz);

    function automatic logic [1:0] fwd_sel(input logic [5:0] r);
        if (stage_match(r_ex, r))       return FWD_EX;
        else if (stage_match(r_mem, r)) return FWD_MEM;
        else if (stage_match(r_wb, r))  return FWD_WB;
        else                            return FWD_RF;
    endfunction

    always_comb begin
        fwd1 = FWD_RF;
        fwd2 = FWD_RF;
        if (id_valid) begin
            fwd1 = fwd_sel(id_rr1);
            fwd2 = fwd_sel(id_rr2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= STAGE_EMPTY;
            r_mem <= STAGE_EMPTY;
            r_wb  <= STAGE_EMPTY;
        end else begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (w_issue) begin
                r_ex <= '{valid: 1'b1, dest: id_wr, is_load: id_is_load};
            end else begin
                r_ex <= STAGE_EMPTY;
            end
        end
    end

    assign w_hilo_load = w_issue && (id_is_mul || id_is_div);
    assign w_hilo_val  = id_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    hilo_busy_counter u_hilo_busy_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load_en  (w_hilo_load),
        .i_load_val (w_hilo_val),
        .o_busy     (w_hilo_busy)
    );

    assign hilo_busy = w_hilo_busy;

endmodule

// File: tb/tb_reg_hazard_unit.sv
// Self-checking bench for reg_hazard_unit: directed vector table, HI/LO and
// reset sequences, then random traffic against a pipeline-history model.
module tb_reg_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_rr1, id_rr2, id_wr;
    logic       id_is_load, id_is_mul, id_is_div, flush;
    logic       stall;
    logic [1:0] fwd1, fwd2;
    logic       hilo_busy;

    int n_cmp = 0;
    int n_bad = 0;

    reg_hazard_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rr1     (id_rr1),
        .id_rr2     (id_rr2),
        .id_wr      (id_wr),
        .id_is_load (id_is_load),
        .id_is_mul  (id_is_mul),
        .id_is_div  (id_is_div),
        .flush      (flush),
        .stall      (stall),
        .fwd1       (fwd1),
        .fwd2       (fwd2),
        .hilo_busy  (hilo_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [5:0] rr1, rr2, wr;
        logic       ld, mul, div, fl;
        logic       st;
        logic [1:0] f1, f2;
        logic       busy;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic v, input logic [5:0] rr1, input logic [5:0] rr2,
                                input logic [5:0] wr, input logic ld, input logic mul,
                                input logic div, input logic fl, input logic st,
                                input logic [1:0] f1, input logic [1:0] f2, input logic busy);
        vec_t t;
        t.v = v; t.rr1 = rr1; t.rr2 = rr2; t.wr = wr;
        t.ld = ld; t.mul = mul; t.div = div; t.fl = fl;
        t.st = st; t.f1 = f1; t.f2 = f2; t.busy = busy;
        return t;
    endfunction

    // driver tasks
    task automatic drive(input logic v, input logic [5:0] rr1, input logic [5:0] rr2,
                         input logic [5:0] wr, input logic ld, input logic mul,
                         input logic div, input logic fl);
        id_valid = v; id_rr1 = rr1; id_rr2 = rr2; id_wr = wr;
        id_is_load = ld; id_is_mul = mul; id_is_div = div; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic st, input logic [1:0] f1,
                           input logic [1:0] f2, input logic busy);
        chk({nm, " stall"}, {7'd0, stall}, {7'd0, st});
        chk({nm, " fwd1"}, {6'd0, fwd1}, {6'd0, f1});
        chk({nm, " fwd2"}, {6'd0, fwd2}, {6'd0, f2});
        chk({nm, " hilo_busy"}, {7'd0, hilo_busy}, {7'd0, busy});
    endtask

    // reference model: last three issue slots (0 = EX, 1 = MEM, 2 = WB)
    typedef struct {
        bit v;
        int d;
        bit ld;
    } slot_t;

    slot_t pipe[3];
    int    m_cnt;

    function automatic bit m_match(input int k, input int r);
        return pipe[k].v && (r != 0) && (pipe[k].d == r);
    endfunction

    function automatic int m_fwd(input bit v, input int r);
        if (!v) return 0;
        for (int k = 0; k < 3; k++) begin
            if (m_match(k, r)) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit m_stall(input bit v, input int r1, input int r2, input bit mul,
                                   input bit div, input bit fl);
        bit haz;
        haz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (pipe[k].ld && (m_match(k, r1) || m_match(k, r2))) haz = 1'b1;
        end
        if (m_cnt > 0 && (r1 == 33 || r2 == 33 || mul || div)) haz = 1'b1;
        return v && !fl && haz;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{v: 0, d: 0, ld: 0};
        m_cnt = 0;
    endtask

    task automatic m_step(input bit issue, input int wr, input bit ld, input bit mul, input bit div);
        if (issue && div)      m_cnt = 16;
        else if (issue && mul) m_cnt = 4;
        else if (m_cnt > 0)    m_cnt = m_cnt - 1;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (issue) pipe[0] = '{v: 1, d: wr, ld: ld};
        else       pipe[0] = '{v: 0, d: 0, ld: 0};
    endtask

    function automatic logic [5:0] pick_reg();
        int sel;
        sel = $urandom_range(0, 6);
        case (sel)
            0:       return 6'd0;
            1:       return 6'd1;
            2:       return 6'd2;
            3:       return 6'd3;
            4:       return 6'd33;
            5:       return 6'd4;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk_all("reset", 1'b0, 2'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // directed vector table, one row per cycle starting from the empty pipeline
        tbl[0]  = mk(1,  1,  2,  8, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        tbl[1]  = mk(1,  8,  0, 10, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0);
        tbl[2]  = mk(0,  8,  0,  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        tbl[3]  = mk(1,  8,  0, 11, 0, 0, 0, 0, 0, 2'd3, 2'd0, 0);
        tbl[4]  = mk(1, 29,  0,  9, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        tbl[5]  = mk(1, 11,  9, 12, 0, 0, 0, 0, 1, 2'd2, 2'd1, 0);
        tbl[6]  = mk(1, 11,  9, 12, 0, 0, 0, 0, 1, 2'd3, 2'd2, 0);
        tbl[7]  = mk(1, 11,  9, 12, 0, 0, 0, 0, 0, 2'd0, 2'd3, 0);
        tbl[8]  = mk(1,  4,  0,  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        tbl[9]  = mk(1,  0, 12,  0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 0);
        tbl[10] = mk(1,  0,  0, 13, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        tbl[11] = mk(1, 13,  0, 14, 0, 0, 0, 1, 0, 2'd1, 2'd0, 0);
        tbl[12] = mk(1, 14, 13,  0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0);
        tbl[13] = mk(1, 14, 13,  0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 0);
        tbl[14] = mk(0, 13, 14,  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].rr1, tbl[i].rr2, tbl[i].wr,
                  tbl[i].ld, tbl[i].mul, tbl[i].div, tbl[i].fl);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].f1, tbl[i].f2, tbl[i].busy);
            next_cycle();
        end

        // DIVU, then MULTU and MFLO wait out the 16-cycle busy window
        drive(1, 2, 3, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("divu stall", {7'd0, stall}, 8'd0);
        chk("divu busy", {7'd0, hilo_busy}, 8'd0);
        next_cycle();
        for (int k = 0; k <= 16; k++) begin
            if (k == 0) drive(1, 4, 5, 0, 0, 1, 0, 0);
            else        drive(1, 33, 0, 8, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("hilo%0d stall", k), {7'd0, stall}, (k < 16) ? 8'd1 : 8'd0);
            chk($sformatf("hilo%0d busy", k), {7'd0, hilo_busy}, (k < 16) ? 8'd1 : 8'd0);
            next_cycle();
        end

        // asynchronous reset while the busy count sits at 9
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) next_cycle();
        drive(1, 0, 0, 7, 0, 0, 0, 0);
        next_cycle();
        drive(1, 33, 7, 9, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("pre_rst", 1'b1, 2'd0, 2'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 1'b0, 2'd0, 2'd0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_n = 1'b1;
        m_reset();

        // random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic v, ld, mul, div, fl;
            logic [5:0] r1, r2, wr;
            bit exp_st;
            int sel;
            v   = ($urandom_range(0, 9) != 0);
            r1  = pick_reg();
            r2  = pick_reg();
            wr  = pick_reg();
            sel = $urandom_range(0, 19);
            ld  = (sel < 6);
            mul = (sel == 6);
            div = (sel == 7);
            fl  = ($urandom_range(0, 11) == 0);
            drive(v, r1, r2, wr, ld, mul, div, fl);
            exp_st = m_stall(v, int'(r1), int'(r2), mul, div, fl);
            @(negedge clk);
            chk_all($sformatf("rnd%0d", i), exp_st, 2'(m_fwd(v, int'(r1))),
                    2'(m_fwd(v, int'(r2))), (m_cnt > 0));
            @(posedge clk);
            m_step(v && !exp_st && !fl, int'(wr), ld, mul, div);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
